// File: rtl/mc_fetch_unit_if.sv
// Fetch-unit bus bundle: FSM fetch handshake, instruction-memory request/response,
// PC redirect and the decoded IR outputs. master = fetch unit, slave = memory/FSM side.
interface mc_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            fetch_req;
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [XLEN-1:0] iresp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] instr;
  logic [5:0]      op;
  logic [5:0]      func;
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            busy;
  logic            addr_err;

  modport master (
    input  fetch_req, iresp_data_ok, iresp_data, redirect_valid, redirect_pc,
    output ireq_valid, ireq_addr, instr, op, func, instr_valid, pc, pc_plus4,
           busy, addr_err
  );

  modport slave (
    output fetch_req, iresp_data_ok, iresp_data, redirect_valid, redirect_pc,
    input  ireq_valid, ireq_addr, instr, op, func, instr_valid, pc, pc_plus4,
           busy, addr_err
  );
endinterface

// File: rtl/mc_fetch_unit.sv
// Multicycle MIPS fetch front end: PC, IR, one imem request per fetch, redirect/kill.
// Optional FETCH_ALIGN_CHECK_EN: misaligned fetch raises addr_err instead of requesting.
module mc_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000
) (
  input logic            clk,
  input logic            reset,
  mc_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
  logic addr_err_q;
  assign bus.addr_err = addr_err_q;
`else
  localparam bit ALIGN_CHK = 1'b0;
  assign bus.addr_err = 1'b0;
`endif

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] instr_q;
  logic            instr_valid_q;
  logic            ireq_valid_q;
  logic            kill;
  logic [XLEN-1:0] nxt_addr;
  logic            misal;

  // A redirect in the same cycle always wins over the current pc as request target.
  always_comb begin
    nxt_addr = bus.redirect_valid ? bus.redirect_pc : pc_q;
    misal    = ALIGN_CHK && (nxt_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pc_q          <= RESET_PC;
      req_addr      <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      ireq_valid_q  <= 1'b0;
      kill          <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      addr_err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (bus.redirect_valid) pc_q <= bus.redirect_pc;
          if (bus.fetch_req) begin
            req_addr      <= nxt_addr;
            kill          <= 1'b0;
            instr_valid_q <= 1'b0;
            ireq_valid_q  <= !misal;
            state         <= REQ;
          end
`ifdef FETCH_ALIGN_CHECK_EN
          if (bus.fetch_req || bus.redirect_valid) addr_err_q <= 1'b0;
`endif
        end
        REQ: begin
          if (!ireq_valid_q) begin
            // REQ entered without a memory request: only a misaligned target gets here.
            if (bus.redirect_valid) pc_q <= bus.redirect_pc;
            instr_q       <= '0;
            instr_valid_q <= 1'b1;
            state         <= HOLD;
`ifdef FETCH_ALIGN_CHECK_EN
            addr_err_q    <= 1'b1;
`endif
          end else if (bus.iresp_data_ok) begin
            if (kill || bus.redirect_valid) begin
              if (bus.redirect_valid) pc_q <= bus.redirect_pc;
              req_addr     <= nxt_addr;
              kill         <= 1'b0;
              ireq_valid_q <= !misal;
            end else begin
              instr_q       <= bus.iresp_data;
              instr_valid_q <= 1'b1;
              pc_q          <= req_addr + XLEN'(4);
              ireq_valid_q  <= 1'b0;
              state         <= HOLD;
            end
          end else if (bus.redirect_valid) begin
            pc_q <= bus.redirect_pc;
            kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ireq_valid  = ireq_valid_q;
  assign bus.ireq_addr   = ALIGN_CHK ? req_addr : (req_addr & ~XLEN'(3));
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:26];
  assign bus.func        = instr_q[5:0];
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + XLEN'(4);
  assign bus.busy        = (state == REQ);

endmodule

// File: tb/tb_mc_fetch_unit.sv
// Directed self-checking bench for mc_fetch_unit; each task drives one scenario and checks inline.
module tb_mc_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   passed = 0;
  int   total  = 0;

  mc_fetch_unit_if #(.XLEN(32)) bus();

  mc_fetch_unit #(.XLEN(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_req      = 1'b0;
    bus.iresp_data_ok  = 1'b0;
    bus.iresp_data     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    total++; if (bus.pc !== 32'hBFC0_0000) $display("FAIL rst_pc: got %h exp %h", bus.pc, 32'hBFC0_0000); else passed++;
    total++; if (bus.pc_plus4 !== 32'hBFC0_0004) $display("FAIL rst_pc4: got %h exp %h", bus.pc_plus4, 32'hBFC0_0004); else passed++;
    total++; if (bus.instr !== 32'h0) $display("FAIL rst_instr: got %h exp 0", bus.instr); else passed++;
    total++; if ({bus.instr_valid, bus.ireq_valid, bus.busy, bus.addr_err} !== 4'b0000)
      $display("FAIL rst_flags: got %b exp 0000", {bus.instr_valid, bus.ireq_valid, bus.busy, bus.addr_err}); else passed++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic_fetch();
    pulse_reset();
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    total++; if (bus.ireq_valid !== 1'b1) $display("FAIL basic_ireq_valid: got %b exp 1", bus.ireq_valid); else passed++;
    total++; if (bus.ireq_addr !== 32'hBFC0_0000) $display("FAIL basic_addr: got %h exp %h", bus.ireq_addr, 32'hBFC0_0000); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL basic_early_valid: got %b exp 0", bus.instr_valid); else passed++;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'h2008_0005;
    tick();
    bus.iresp_data_ok = 1'b0;
    total++; if (bus.instr_valid !== 1'b1) $display("FAIL basic_valid: got %b exp 1", bus.instr_valid); else passed++;
    total++; if (bus.instr !== 32'h2008_0005) $display("FAIL basic_instr: got %h exp %h", bus.instr, 32'h2008_0005); else passed++;
    total++; if (bus.op !== 6'h08) $display("FAIL basic_op: got %h exp 08", bus.op); else passed++;
    total++; if (bus.func !== 6'h05) $display("FAIL basic_func: got %h exp 05", bus.func); else passed++;
    total++; if (bus.pc !== 32'hBFC0_0004) $display("FAIL basic_pc: got %h exp %h", bus.pc, 32'hBFC0_0004); else passed++;
    total++; if (bus.ireq_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL basic_release: got valid=%b busy=%b exp 0 0", bus.ireq_valid, bus.busy); else passed++;
  endtask

  task automatic test_wait_states();
    pulse_reset();
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.ireq_valid !== 1'b1 || bus.busy !== 1'b1)
        $display("FAIL wait_hold%0d: got valid=%b busy=%b exp 1 1", i, bus.ireq_valid, bus.busy); else passed++;
      total++; if (bus.ireq_addr !== 32'hBFC0_0000) $display("FAIL wait_addr%0d: got %h exp %h", i, bus.ireq_addr, 32'hBFC0_0000); else passed++;
      total++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0)
        $display("FAIL wait_ir%0d: got v=%b %h exp 0 0", i, bus.instr_valid, bus.instr); else passed++;
      bus.iresp_data_ok = (i == 3);
      bus.iresp_data    = (i == 3) ? 32'h8C08_0004 : 32'hFFFF_FFFF;
      tick();
    end
    bus.iresp_data_ok = 1'b0;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h8C08_0004)
      $display("FAIL wait_load: got v=%b %h exp 1 %h", bus.instr_valid, bus.instr, 32'h8C08_0004); else passed++;
    total++; if (bus.pc !== 32'hBFC0_0004) $display("FAIL wait_pc: got %h exp %h", bus.pc, 32'hBFC0_0004); else passed++;
  endtask

  task automatic test_redirect_hold();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hBFC0_0100;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.pc !== 32'hBFC0_0100) $display("FAIL rh_pc: got %h exp %h", bus.pc, 32'hBFC0_0100); else passed++;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h8C08_0004)
      $display("FAIL rh_ir_kept: got v=%b %h exp 1 %h", bus.instr_valid, bus.instr, 32'h8C08_0004); else passed++;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    total++; if (bus.ireq_addr !== 32'hBFC0_0100) $display("FAIL rh_addr: got %h exp %h", bus.ireq_addr, 32'hBFC0_0100); else passed++;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'h0000_0020;
    tick();
    bus.iresp_data_ok = 1'b0;
    total++; if (bus.pc !== 32'hBFC0_0104 || bus.pc_plus4 !== 32'hBFC0_0108)
      $display("FAIL rh_pc_after: got %h/%h exp %h/%h", bus.pc, bus.pc_plus4, 32'hBFC0_0104, 32'hBFC0_0108); else passed++;
    total++; if (bus.func !== 6'h20) $display("FAIL rh_func: got %h exp 20", bus.func); else passed++;
    // Redirect and fetch_req in the same cycle
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hBFC0_0200;
    bus.fetch_req      = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.fetch_req      = 1'b0;
    total++; if (bus.ireq_addr !== 32'hBFC0_0200 || bus.pc !== 32'hBFC0_0200)
      $display("FAIL rh_same_cycle: got addr=%h pc=%h exp %h", bus.ireq_addr, bus.pc, 32'hBFC0_0200); else passed++;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'h1000_0003;
    tick();
    bus.iresp_data_ok = 1'b0;
    total++; if (bus.pc !== 32'hBFC0_0204) $display("FAIL rh_same_pc: got %h exp %h", bus.pc, 32'hBFC0_0204); else passed++;
  endtask

  task automatic test_kill();
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0040;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.pc !== 32'h8000_0040) $display("FAIL kill_pc: got %h exp %h", bus.pc, 32'h8000_0040); else passed++;
    total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hBFC0_0204)
      $display("FAIL kill_old_req: got v=%b %h exp 1 %h", bus.ireq_valid, bus.ireq_addr, 32'hBFC0_0204); else passed++;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'hDEAD_BEEF;
    tick();
    total++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h1000_0003)
      $display("FAIL kill_drop: got v=%b %h exp 0 %h", bus.instr_valid, bus.instr, 32'h1000_0003); else passed++;
    total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h8000_0040)
      $display("FAIL kill_reissue: got v=%b %h exp 1 %h", bus.ireq_valid, bus.ireq_addr, 32'h8000_0040); else passed++;
    bus.iresp_data = 32'h0C00_0010;
    tick();
    bus.iresp_data_ok = 1'b0;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0C00_0010 || bus.op !== 6'h03)
      $display("FAIL kill_new: got v=%b %h op=%h exp 1 %h 03", bus.instr_valid, bus.instr, bus.op, 32'h0C00_0010); else passed++;
    total++; if (bus.pc !== 32'h8000_0044) $display("FAIL kill_pc_after: got %h exp %h", bus.pc, 32'h8000_0044); else passed++;
    // Redirect coinciding with data_ok, then two redirects while killed
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    bus.iresp_data_ok  = 1'b1;
    bus.iresp_data     = 32'h1111_1111;
    tick();
    bus.iresp_data_ok = 1'b0;
    total++; if (bus.instr_valid !== 1'b0 || bus.ireq_addr !== 32'h8000_0100 || bus.pc !== 32'h8000_0100)
      $display("FAIL kill_coincide: got v=%b addr=%h pc=%h exp 0 %h %h", bus.instr_valid, bus.ireq_addr, bus.pc, 32'h8000_0100, 32'h8000_0100); else passed++;
    bus.redirect_pc = 32'h8000_0200;
    tick();
    bus.redirect_pc = 32'h8000_0300;
    tick();
    bus.redirect_valid = 1'b0;
    bus.iresp_data_ok  = 1'b1;
    bus.iresp_data     = 32'h3333_3333;
    tick();
    total++; if (bus.instr_valid !== 1'b0 || bus.ireq_addr !== 32'h8000_0300)
      $display("FAIL kill_last_wins: got v=%b %h exp 0 %h", bus.instr_valid, bus.ireq_addr, 32'h8000_0300); else passed++;
    bus.iresp_data = 32'h2222_2222;
    tick();
    bus.iresp_data_ok = 1'b0;
    total++; if (bus.instr !== 32'h2222_2222 || bus.pc !== 32'h8000_0304)
      $display("FAIL kill_last_load: got %h pc=%h exp %h %h", bus.instr, bus.pc, 32'h2222_2222, 32'h8000_0304); else passed++;
  endtask

  task automatic test_wrap_async_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.pc_plus4 !== 32'h0) $display("FAIL wrap_pc4: got %h exp 0", bus.pc_plus4); else passed++;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req     = 1'b0;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'h0000_0000;
    tick();
    bus.iresp_data_ok = 1'b0;
    total++; if (bus.pc !== 32'h0 || bus.instr_valid !== 1'b1)
      $display("FAIL wrap_pc: got %h v=%b exp 0 1", bus.pc, bus.instr_valid); else passed++;
    bus.fetch_req = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    total++; if (bus.busy !== 1'b1 || bus.ireq_valid !== 1'b1)
      $display("FAIL ar_inflight: got busy=%b v=%b exp 1 1", bus.busy, bus.ireq_valid); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.ireq_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL ar_drop: got v=%b busy=%b exp 0 0", bus.ireq_valid, bus.busy); else passed++;
    total++; if (bus.pc !== 32'hBFC0_0000 || bus.instr !== 32'h0)
      $display("FAIL ar_state: got pc=%h instr=%h exp %h 0", bus.pc, bus.instr, 32'hBFC0_0000); else passed++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_align();
    pulse_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hBFC0_0102;
    tick();
    bus.redirect_valid = 1'b0;
    bus.fetch_req      = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    total++; if (bus.ireq_valid !== 1'b0) $display("FAIL al_noreq: got %b exp 0", bus.ireq_valid); else passed++;
    tick();
    total++; if (bus.ireq_valid !== 1'b0 || bus.addr_err !== 1'b1)
      $display("FAIL al_err: got v=%b err=%b exp 0 1", bus.ireq_valid, bus.addr_err); else passed++;
    total++; if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h0)
      $display("FAIL al_ir: got v=%b %h exp 1 0", bus.instr_valid, bus.instr); else passed++;
    total++; if (bus.pc !== 32'hBFC0_0102) $display("FAIL al_pc: got %h exp %h", bus.pc, 32'hBFC0_0102); else passed++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hBFC0_0000;
    tick();
    bus.redirect_valid = 1'b0;
    total++; if (bus.addr_err !== 1'b0) $display("FAIL al_clear: got %b exp 0", bus.addr_err); else passed++;
`else
    total++; if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hBFC0_0100)
      $display("FAIL al_forced: got v=%b %h exp 1 %h", bus.ireq_valid, bus.ireq_addr, 32'hBFC0_0100); else passed++;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'h2408_0001;
    tick();
    bus.iresp_data_ok = 1'b0;
    total++; if (bus.addr_err !== 1'b0 || bus.instr !== 32'h2408_0001)
      $display("FAIL al_noerr: got err=%b %h exp 0 %h", bus.addr_err, bus.instr, 32'h2408_0001); else passed++;
    total++; if (bus.pc !== 32'hBFC0_0106) $display("FAIL al_pc: got %h exp %h", bus.pc, 32'hBFC0_0106); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_redirect_hold();
    test_kill();
    test_wrap_async_reset();
    test_align();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
